// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DIV_MIN        smallest divisor that produces a running channel
//   hi_len()       number of high cycles in a period of length d (ceil(d/2))
//   div_init_vec() default reset divisors: channel k gets 100000000 >> k
package clk_div_pkg;

    localparam int DIV_MIN = 2;

    // Wide enough to hold the default vector for any sensible N_CH * DIV_W.
    localparam int INIT_VEC_W = 1024;

    function automatic logic [31:0] hi_len(input logic [31:0] d);
        return d - (d >> 1);
    endfunction

    function automatic logic [INIT_VEC_W-1:0] div_init_vec(input int n_ch, input int div_w);
        logic [INIT_VEC_W-1:0] v;
        logic [63:0]           mask;
        v    = '0;
        mask = (64'd1 << div_w) - 64'd1;
        for (int k = 0; k < n_ch; k++) begin
            v = v | (INIT_VEC_W'((64'd100000000 >> k) & mask) << (k * div_w));
        end
        return v;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, divided clock and tick.
// Latency: outputs are registered together with the counter (decoded from next-state count).
// Backpressure: none; a load is always accepted and becomes active at the next period boundary.
//
// Ports:
//   clki, rst        clock, asynchronous active-high reset
//   en, sync         channel enable (level), phase restart pulse
//   load, load_div   shadow divisor write strobe and value
//   pending          shadow written but not yet active
//   clko, tick       divided clock, last-cycle-of-period strobe
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               DIV_W   = 27,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(2)
) (
    input  logic             clki,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             pending,
    output logic             clko,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act;
    logic [DIV_W-1:0] shd;
    // Set while the channel counted through the previous cycle; a channel
    // that was stopped (disabled, idle or just out of reset) starts at cnt 0.
    logic             run;

    logic             idle;
    logic             wrap;
    logic             apply;
    logic             go;
    logic [DIV_W-1:0] d_nxt;
    logic [DIV_W-1:0] cnt_nxt;

    always_comb begin
        idle  = act < DIV_W'(DIV_MIN);
        wrap  = run && (cnt == act - DIV_W'(1));
        // Any of these is a period boundary, so swapping the divisor cannot glitch.
        apply = pending && (!en || idle || sync || wrap);
        d_nxt = apply ? shd : act;
        go    = en && (d_nxt >= DIV_W'(DIV_MIN));
        if (!go) begin
            cnt_nxt = '0;
        end else if (sync || !run || wrap) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            act     <= DIV_RST;
            shd     <= DIV_RST;
            pending <= 1'b0;
            run     <= 1'b0;
            clko    <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            act  <= d_nxt;
            run  <= go;
            clko <= go && (cnt_nxt < DIV_W'(hi_len(32'(d_nxt))));
            tick <= go && (cnt_nxt == d_nxt - DIV_W'(1));
            // A write landing on an apply edge stays pending for the next boundary.
            if (load) begin
                shd     <= load_div;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH runtime-programmable clock dividers with shadowed divisor writes.
// Latency: config write visible on pending one cycle later; cfg_err one cycle after the bad write.
// Backpressure: none; writes are always accepted, writes to a nonexistent channel are dropped.
//
// Ports:
//   clki, rst                  clock, asynchronous active-high reset
//   en[N_CH], sync             per-channel enable, global phase restart pulse
//   cfg_we, cfg_ch, cfg_div    divisor write strobe, target channel, value
//   cfg_err                    pulse for a write to cfg_ch >= N_CH
//   pending, clko, tick        per-channel shadow-pending, divided clock, tick
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int                      N_CH     = 3,
    parameter int                      DIV_W    = 27,
    parameter logic [N_CH*DIV_W-1:0]   DIV_INIT = (N_CH*DIV_W)'(div_init_vec(N_CH, DIV_W)),
    localparam int                     CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clki,
    input  logic              rst,
    input  logic [N_CH-1:0]   en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   clko,
    output logic [N_CH-1:0]   tick
);

    logic [N_CH-1:0] load;

    always_comb begin
        load = '0;
        for (int k = 0; k < N_CH; k++) begin
            load[k] = cfg_we && (32'(cfg_ch) == k);
        end
    end

    always_ff @(posedge clki or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && (32'(cfg_ch) >= N_CH);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_INIT[k*DIV_W +: DIV_W])
        ) u_chan (
            .clki     (clki),
            .rst      (rst),
            .en       (en[k]),
            .sync     (sync),
            .load     (load[k]),
            .load_div (cfg_div),
            .pending  (pending[k]),
            .clko     (clko[k]),
            .tick     (tick[k])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank against a period-position reference model.
// Latency: expectations are updated once per rising edge and compared 1 time unit later.
// Backpressure: n/a.
module tb_clk_div_bank;

    localparam int N_CH  = 3;
    localparam int DIV_W = 8;
    localparam int CH_W  = 2;
    localparam logic [N_CH*DIV_W-1:0] INIT = {8'd8, 8'd5, 8'd4};

    logic              clki    = 1'b0;
    logic              rst     = 1'b1;
    logic [N_CH-1:0]   en      = '0;
    logic              sync    = 1'b0;
    logic              cfg_we  = 1'b0;
    logic [CH_W-1:0]   cfg_ch  = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              cfg_err;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   clko;
    logic [N_CH-1:0]   tick;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: position within the current period (-1 = stopped),
    // active divisor, shadow divisor and pending flag per channel.
    int              m_pos  [N_CH];
    int              m_div  [N_CH];
    int              m_shd  [N_CH];
    bit              m_pend [N_CH];
    logic [N_CH-1:0] x_clko;
    logic [N_CH-1:0] x_tick;
    logic [N_CH-1:0] x_pend;
    logic            x_err;

    clk_div_bank #(
        .N_CH     (N_CH),
        .DIV_W    (DIV_W),
        .DIV_INIT (INIT)
    ) dut (
        .clki    (clki),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_err (cfg_err),
        .pending (pending),
        .clko    (clko),
        .tick    (tick)
    );

    always #5 clki = ~clki;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int init_of(input int k);
        return int'(INIT[k*DIV_W +: DIV_W]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_pos[k]  = -1;
            m_div[k]  = init_of(k);
            m_shd[k]  = init_of(k);
            m_pend[k] = 1'b0;
        end
        x_clko = '0;
        x_tick = '0;
        x_pend = '0;
        x_err  = 1'b0;
    endtask

    task automatic model_edge();
        x_err = cfg_we && (int'(cfg_ch) >= N_CH);
        for (int k = 0; k < N_CH; k++) begin
            int old_div;
            bit at_end;
            bit boundary;
            old_div  = m_div[k];
            at_end   = (m_pos[k] >= 0) && (m_pos[k] == old_div - 1);
            boundary = !en[k] || (old_div < 2) || sync || at_end;
            if (m_pend[k] && boundary) begin
                m_div[k]  = m_shd[k];
                m_pend[k] = 1'b0;
            end
            if (cfg_we && int'(cfg_ch) == k) begin
                m_shd[k]  = int'(cfg_div);
                m_pend[k] = 1'b1;
            end
            if (!en[k] || m_div[k] < 2)
                m_pos[k] = -1;
            else if (sync || m_pos[k] < 0 || at_end)
                m_pos[k] = 0;
            else
                m_pos[k] = m_pos[k] + 1;
            x_clko[k] = (m_pos[k] >= 0) && (m_pos[k] < m_div[k] - m_div[k] / 2);
            x_tick[k] = (m_pos[k] >= 0) && (m_pos[k] == m_div[k] - 1);
            x_pend[k] = m_pend[k];
        end
    endtask

    task automatic step();
        @(posedge clki);
        model_edge();
        #1;
        check_eq("clko",    32'(clko),    32'(x_clko));
        check_eq("tick",    32'(tick),    32'(x_tick));
        check_eq("pending", 32'(pending), 32'(x_pend));
        check_eq("cfg_err", 32'(cfg_err), 32'(x_err));
    endtask

    task automatic write_cfg(input int ch, input int div);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_div = DIV_W'(div);
        step();
        cfg_we  = 1'b0;
    endtask

    initial begin
        bit d4_clk [4];
        bit d4_tck [4];
        bit d3_clk [3];
        bit seen;
        d4_clk = '{1'b1, 1'b1, 1'b0, 1'b0};
        d4_tck = '{1'b0, 1'b0, 1'b0, 1'b1};
        d3_clk = '{1'b1, 1'b1, 1'b0};

        // Reset state
        model_reset();
        #12;
        check_eq("rst_clko",    32'(clko),    32'd0);
        check_eq("rst_tick",    32'(tick),    32'd0);
        check_eq("rst_pending", 32'(pending), 32'd0);
        check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        en  = '1;

        // 1: free-running with reset divisors 4/5/8
        for (int i = 0; i < 20; i++) begin
            step();
            if (i < 4) begin
                check_eq("d4_clko", 32'(clko[0]), 32'(d4_clk[i]));
                check_eq("d4_tick", 32'(tick[0]), 32'(d4_tck[i]));
            end
        end

        // 2: mid-period divisor change on ch0
        step();
        write_cfg(0, 6);
        check_eq("ch0_pend_set", 32'(pending[0]), 32'd1);
        repeat (16) step();

        // 3: illegal divisor idles ch1, then a legal one restarts at once
        write_cfg(1, 1);
        repeat (12) step();
        check_eq("ch1_idle_clko", 32'(clko[1]), 32'd0);
        check_eq("ch1_idle_tick", 32'(tick[1]), 32'd0);
        write_cfg(1, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("d3_clko", 32'(clko[1]), 32'(d3_clk[i]));
        end
        repeat (4) step();

        // 4: sync with a pending shadow on ch2
        write_cfg(2, 6);
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_eq("sync_clko", 32'(clko), 32'b111);
        check_eq("sync_pend2", 32'(pending[2]), 32'd0);
        repeat (10) step();

        // 5: write to a nonexistent channel, then disable ch2 while high
        write_cfg(3, 7);
        check_eq("err_pulse", 32'(cfg_err), 32'd1);
        step();
        check_eq("err_clear", 32'(cfg_err), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = clko[2];
        end
        check_eq("ch2_high_found", 32'(seen), 32'd1);
        en[2] = 1'b0;
        step();
        check_eq("ch2_dis_clko", 32'(clko[2]), 32'd0);
        repeat (3) step();
        en[2] = 1'b1;
        step();
        check_eq("ch2_restart_clko", 32'(clko[2]), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39, 0) == 0) en[$urandom_range(N_CH-1, 0)] ^= 1'b1;
            sync    = ($urandom_range(29, 0) == 0);
            cfg_we  = ($urandom_range(5, 0) == 0);
            cfg_ch  = CH_W'($urandom_range(3, 0));
            cfg_div = DIV_W'($urandom_range(12, 0));
            step();
        end
        sync   = 1'b0;
        cfg_we = 1'b0;

        // 6: asynchronous reset mid-count with a pending shadow
        en = '1;
        repeat (3) step();
        write_cfg(0, 9);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_clko",    32'(clko),    32'd0);
        check_eq("arst_tick",    32'(tick),    32'd0);
        check_eq("arst_pending", 32'(pending), 32'd0);
        model_reset();
        #2;
        rst = 1'b0;
        repeat (24) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
